// File: rtl/product_accumulator.sv
// product_accumulator: sums a frame of unsigned 8-bit products into a
// 12-bit result and counts the terms in the frame. A frame closes on
// in_last, or when MAX_TERMS products have been accepted (flagged by
// forced). The result is held with out_valid until it is taken.
//
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   product present
//   in_ready   block accepts a product this cycle (registered)
//   product    unsigned product, 0..225
//   in_last    final product of the frame
//   out_valid  frame result held on sum/count/forced (registered)
//   out_ready  downstream accepts the result
//   sum        sum of the frame's products
//   count      number of products in the frame, 1..MAX_TERMS
//   forced     frame closed by reaching MAX_TERMS without in_last
module product_accumulator #(
  parameter int unsigned MAX_TERMS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  product,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] sum,
  output logic [4:0]  count,
  output logic        forced
);

  localparam int unsigned SUM_W = 12;
  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_TERMS);
  localparam logic SINGLE_TERM = (MAX_TERMS == 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               forced_q, forced_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic               in_xfer;
  logic [CNT_W-1:0]   count_inc;

  // Handshake flags are flops decoded from the next state, so neither
  // depends combinationally on in_valid or out_ready.
  assign in_xfer   = in_valid && in_ready_q;
  assign count_inc = count_q + CNT_W'(1);

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sum_q       <= '0;
      count_q     <= '0;
      forced_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      count_q     <= count_d;
      forced_q    <= forced_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    count_d  = count_q;
    forced_d = forced_q;

    unique case (state_q)
      IDLE: begin
        if (in_xfer) begin
          sum_d   = SUM_W'(product);
          count_d = CNT_W'(1);
          if (in_last || SINGLE_TERM) begin
            state_d  = DONE;
            forced_d = !in_last;
          end else begin
            state_d  = ACCUM;
            forced_d = 1'b0;
          end
        end
      end
      ACCUM: begin
        if (in_xfer) begin
          sum_d   = sum_q + SUM_W'(product);
          count_d = count_inc;
          if (in_last || (count_inc == CNT_LIMIT)) begin
            state_d  = DONE;
            forced_d = !in_last;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready_d  = (state_d != DONE);
  assign out_valid_d = (state_d == DONE);

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign count     = count_q;
  assign forced    = forced_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Testbench for product_accumulator: directed frames plus random frames,
// checked against a frame-level reference model (running sum/count of
// accepted products, closing rule from in_last / MAX_TERMS).
module tb_product_accumulator;

  localparam int unsigned MAX_TERMS = 16;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  product;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] sum;
  logic [4:0]  count;
  logic        forced;

  int n_cmp;
  int n_bad;

  // Reference model state: the frame currently being built or held
  int m_sum;
  int m_cnt;
  bit m_forced;
  bit m_done;

  product_accumulator #(.MAX_TERMS(MAX_TERMS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .product   (product),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .count     (count),
    .forced    (forced)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_sum = 0; m_cnt = 0; m_forced = 0; m_done = 0;
  endtask

  // Offer one product; wait (bounded) for in_ready, then let it be accepted.
  task automatic put(input int p, input bit last);
    int w;
    w = 0;
    @(negedge clk);
    in_valid = 1'b1;
    product  = 8'(p);
    in_last  = last;
    while (!in_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("put_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    m_sum = m_sum + p;
    m_cnt = m_cnt + 1;
    if (last || m_cnt == MAX_TERMS) begin
      m_done   = 1;
      m_forced = !last;
    end
    #1;
    in_valid = 1'b0;
    product  = 8'($urandom);
    in_last  = 1'($urandom);
  endtask

  // Compare handshake flags and, when a result is held, the result.
  task automatic check_out(input string tag);
    @(negedge clk);
    chk({tag, "_ovalid"}, 32'(out_valid), 32'(m_done));
    chk({tag, "_iready"}, 32'(in_ready), 32'(!m_done));
    if (m_done) begin
      chk({tag, "_sum"},    32'(sum),    32'(m_sum));
      chk({tag, "_count"},  32'(count),  32'(m_cnt));
      chk({tag, "_forced"}, 32'(forced), 32'(m_forced));
    end
  endtask

  // Hold out_ready low for n cycles, result must stay put.
  task automatic stall(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      check_out(tag);
    end
  endtask

  // Take the held result; the block must be idle (no result) afterwards.
  task automatic take(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    model_clear();
    @(negedge clk);
    chk({tag, "_take_ovalid"}, 32'(out_valid), 32'd0);
    chk({tag, "_take_iready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int len;
    int p;
    n_cmp = 0;
    n_bad = 0;
    model_clear();
    rst_n = 1'b0; in_valid = 1'b1; product = 8'd99; in_last = 1'b1; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("rst_iready", 32'(in_ready), 32'd1);
    chk("rst_ovalid", 32'(out_valid), 32'd0);
    chk("rst_sum",    32'(sum),    32'd0);
    chk("rst_count",  32'(count),  32'd0);
    chk("rst_forced", 32'(forced), 32'd0);
    rst_n = 1'b1;

    // Three-term frame
    put(15, 0); put(30, 0); put(225, 1);
    check_out("f3");
    chk("f3_sum_const", 32'(sum), 32'd270);
    take("f3");

    // Single product
    put(100, 1);
    check_out("f1");
    chk("f1_count_const", 32'(count), 32'd1);
    take("f1");

    // Sixteen max products, closed by the term limit; a 17th waits
    for (int i = 0; i < 16; i++) put(225, 0);
    check_out("f16");
    chk("f16_sum_const", 32'(sum), 32'd3600);
    chk("f16_forced_const", 32'(forced), 32'd1);
    @(negedge clk);
    in_valid = 1'b1; product = 8'd225; in_last = 1'b0;
    stall("f16_hold", 3);
    take("f16");
    in_valid = 1'b0;
    put(5, 1);
    check_out("f17");
    take("f17");

    // Backpressure: five cycles of out_ready low
    put(40, 0); put(50, 1);
    check_out("bp");
    stall("bp", 5);
    take("bp");
    put(9, 1);
    check_out("bp_next");
    take("bp_next");

    // out_ready high while accumulating has no effect
    @(negedge clk);
    out_ready = 1'b1;
    put(11, 0);
    check_out("orq_acc");
    @(negedge clk);
    out_ready = 1'b0;
    put(12, 1);
    check_out("orq_done");
    take("orq");

    // Reset mid-frame discards the partial frame
    put(10, 0); put(20, 0);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; product = 8'd77; out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    model_clear();
    @(negedge clk);
    chk("mrst_sum",    32'(sum),    32'd0);
    chk("mrst_count",  32'(count),  32'd0);
    chk("mrst_ovalid", 32'(out_valid), 32'd0);
    chk("mrst_iready", 32'(in_ready), 32'd1);
    put(7, 1);
    check_out("mrst_next");
    take("mrst_next");

    // Gaps between products with garbage on the bus
    put(1, 0);
    repeat (2) @(posedge clk);
    put(2, 0);
    repeat (3) @(posedge clk);
    put(3, 1);
    check_out("gap");
    chk("gap_sum_const", 32'(sum), 32'd6);
    take("gap");

    // Random frames, some overrun the term limit
    for (int f = 0; f < 25; f++) begin
      len = int'($urandom_range(1, 18));
      for (int i = 0; i < len && !m_done; i++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        p = int'($urandom_range(0, 225));
        put(p, i == len - 1);
      end
      check_out("rnd");
      stall("rnd_stall", int'($urandom_range(0, 3)));
      take("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog timeout compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter MAX_TERMS, default 16, maximum number of products per accumulation frame (legal range 1..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream product present on product.
REQ-005 SHALL have port in_ready  output  1  block accepts product this cycle.
REQ-006 SHALL have port product  input  8  unsigned 4x4 multiplier result, 0..225.
REQ-007 SHALL have port in_last  input  1  marks final product of a frame; sampled with product.
REQ-008 SHALL have port out_valid  output  1  frame result held on sum/count.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-010 SHALL have port sum  output  12  unsigned sum of the frame's products.
REQ-011 SHALL have port count  output  5  number of products in the frame, 1..16.
REQ-012 SHALL have port forced  output  1  frame was closed by reaching MAX_TERMS without in_last.

Function
REQ-013 SHALL define input transfer as in_valid && in_ready on a rising edge; output transfer as out_valid && out_ready.
REQ-014 SHALL implement states IDLE, ACCUM, DONE.
REQ-015 SHALL, in IDLE: in_ready=1, out_valid=0; on transfer, sum<=product, count<=1, then go to DONE if in_last or MAX_TERMS==1, else ACCUM.
REQ-016 SHALL, in ACCUM: in_ready=1, out_valid=0; on transfer, sum<=sum+product, count<=count+1; go to DONE when in_last or new count==MAX_TERMS, else stay.
REQ-017 SHALL set forced=1 when a frame enters DONE through count reaching MAX_TERMS with in_last=0; forced=0 otherwise.
REQ-018 SHALL, in DONE: in_ready=0, out_valid=1, sum/count/forced held stable until output transfer.
REQ-019 SHALL, on output transfer in DONE, return to IDLE next cycle; no input accepted in the same cycle (one bubble cycle per frame).
REQ-020 SHALL hold sum/count/forced unchanged in any cycle without an input transfer.
REQ-021 SHALL compute sum at 12 bits without truncation; 16*225=3600 cannot overflow.
REQ-022 SHALL ignore product and in_last whenever in_valid=0 or in_ready=0.
REQ-023 SHALL have latency of one cycle from the accepting edge of the closing product to out_valid=1.
REQ-024 SHALL ignore out_ready outside DONE.
REQ-025 SHALL derive in_ready and out_valid only from state (no combinational path from in_valid or out_ready).

Reset
REQ-026 SHALL, when rst_n=0 at a rising edge, enter IDLE with sum=0, count=0, forced=0, out_valid=0, in_ready=1 next cycle, regardless of state.
REQ-027 SHALL discard any partial or unread frame on reset mid-operation; no result for it ever appears.
REQ-028 SHALL ignore in_valid and out_ready in cycles where rst_n=0.

Verification
REQ-029 Frame of 3: products 15,30,225 (last on 225), out_ready=1 -> out_valid one cycle after third accept, sum=270, count=3, forced=0.
REQ-030 Single product 100 with in_last=1 -> DONE next cycle, sum=100, count=1, forced=0; in_ready=0 while DONE.
REQ-031 16 products of 225 without in_last -> sum=3600, count=16, forced=1; 17th product not accepted until output transfer.
REQ-032 Backpressure: out_ready=0 for 5 cycles in DONE -> sum/count/forced stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle, then next frame accepted.
REQ-033 Reset mid-frame after products 10,20 -> IDLE, sum=0, count=0; following frame 7 (last) -> sum=7, count=1.
REQ-034 Gaps: in_valid toggled with idle cycles between products 1,2,3 (last) -> sum=6, count=3; product values while in_valid=0 do not affect sum.
